multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
// - Multi-cycle FSM control unit for the 8-bit accumulator CPU; successor to the single-cycle opcode decoder.
// - Sequences FETCH/DECODE/EXEC/WB/HALT, waits on a memory ready handshake, and adds HALT/resume and conditional skip.
// - Sits between the instruction register, PC, accumulator/ALU datapath and the memory port.
// PARAMETERS
// - OPCODE_W  3  opcode width, >=3; codes >=8 are illegal.
// - ALU_OP_W  2  ALU op select width, >=2.
// - TIMEOUT   16 mem_ready wait limit in cycles; used only with CTRL_TIMEOUT_EN.
// PORTS
// - clk        in  1         clock, rising edge
// - rst_n      in  1         asynchronous active-low reset
// - opcode     in  OPCODE_W  opcode field from instruction register
// - acc_zero   in  1         accumulator == 0
// - mem_ready  in  1         memory completes current read/write this cycle
// - resume     in  1         leave HALT
// - ir_load    out 1         IR may load; datapath qualifies with mem_ready
// - pc_inc     out 1         increment PC
// - mem_read   out 1         memory read request, level
// - mem_write  out 1         memory write request, level
// - jump       out 1         PC <= operand address
// - skip       out 1         PC += 1 (skip next instruction)
// - acc_write  out 1         accumulator write enable
// - alu_to_acc out 1         1 selects ALU result; 0 selects memory data into ACC
// - alu_op     out ALU_OP_W  00 pass, 01 ADD, 10 AND, 11 XOR
// - reg_write  out 1         register-file write enable
// - halted     out 1         in HALT state
// - illegal_op out 1         one-cycle pulse on an illegal opcode
// - bus_error  out 1         one-cycle pulse on a mem_ready timeout
// - state      out 3         FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB, 4 HALT
// BEHAVIOUR
// - Moore outputs: each output depends only on the state register, op_q and skz_q; no combinational input-to-output path.
// - Reset (async): state=FETCH, op_q=0, skz_q=0, timeout counter 0, illegal_op=0, bus_error=0.
//   Other outputs follow the FETCH decode (mem_read=1, ir_load=1).
// - Reset mid-operation abandons the in-flight transaction; no write completes after rst_n falls.
// - FETCH: mem_read=1, ir_load=1. Stays until mem_ready, then -> DECODE.
// - DECODE (1 cycle): pc_inc=1, op_q<=opcode, skz_q<=acc_zero. Next state:
//   - 000 HLT -> HALT.
//   - illegal opcode -> FETCH, with illegal_op pulsed in the following cycle.
//   - all others -> EXEC.
// - EXEC, by op_q:
//   - 001 JMP: jump=1 for 1 cycle -> FETCH.
//   - 111 SKZ: skip=skz_q for 1 cycle -> FETCH.
//   - 010 ADD / 011 AND / 100 XOR: mem_read=1, alu_to_acc=1, alu_op=01/10/11. On mem_ready -> WB.
//   - 101 LDA: mem_read=1, alu_to_acc=0, alu_op=00. On mem_ready -> WB.
//   - 110 STO: mem_write=1. On mem_ready -> FETCH.
// - WB (1 cycle): acc_write=1, reg_write=1; alu_to_acc and alu_op held from EXEC -> FETCH.
// - HALT: halted=1, all other strobes 0. resume sampled high -> FETCH; resume is ignored in other states.
// - Cycle counts with mem_ready always high: JMP/SKZ/STO 3, ADD/AND/XOR/LDA 4, HLT 2 then HALT.
// - Any undriven strobe is 0. mem_read and mem_write are never both 1.
// CONFIGURATION
// - CTRL_TIMEOUT_EN defined:
//   - An 8-bit counter counts cycles spent in FETCH or EXEC with mem_ready low.
//   - On reaching TIMEOUT: pulse bus_error for 1 cycle, go to FETCH, clear counter.
//   - Counter also clears on every state change.
// - CTRL_TIMEOUT_EN undefined: wait indefinitely; bus_error tied 0; no counter logic.
// STRUCTURE
// - Package ctrl_pkg:
//   - opcode constants OP_HLT..OP_SKZ;
//   - state enum ctrl_state_t;
//   - ALU op constants ALU_PASS/ADD/AND/XOR;
//   - ctrl_word_t struct holding all strobes.
// - Sub-module ctrl_decode: combinational (state, op_q, skz_q) -> ctrl_word_t.
//   Top level holds the state register, op_q, skz_q and the optional timeout counter.
// TESTING
// - Reset in FETCH: assert rst_n=0 mid-cycle -> state=0, mem_read=1, ir_load=1, all other strobes 0 immediately.
// - ADD with ready high: opcode=010 -> states 0,1,2,3,0; alu_op=01 in EXEC and WB; acc_write=1 only in WB; pc_inc exactly once.
// - STO with mem_ready low for 5 cycles -> mem_write held 6 cycles, then FETCH; reg_write never asserts.
// - SKZ: acc_zero=1 at DECODE -> skip=1 for 1 cycle; acc_zero=0 -> skip stays 0.
// - HLT: state=4, halted=1, stays 20 cycles; resume=1 -> FETCH next cycle. OPCODE_W=4, opcode=1000 -> illegal_op pulse, back to FETCH.
// - CTRL_TIMEOUT_EN defined, TIMEOUT=16: mem_ready low in EXEC -> bus_error pulse after 16 cycles, then FETCH. Undefined: still waiting, bus_error=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle accumulator CPU controller.
// Optional feature macro: CTRL_TIMEOUT_EN (mem_ready wait timeout / bus_error).
package ctrl_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned ALU_W   = 2;
  localparam int unsigned STATE_W = 3;

  // Opcode encodings (low three bits of the IR opcode field)
  localparam logic [OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [OP_W-1:0] OP_JMP = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [OP_W-1:0] OP_STO = 3'd6;
  localparam logic [OP_W-1:0] OP_SKZ = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    CS_FETCH  = 3'd0,
    CS_DECODE = 3'd1,
    CS_EXEC   = 3'd2,
    CS_WB     = 3'd3,
    CS_HALT   = 3'd4
  } ctrl_state_t;

  // Plain-vector state codes for the state register and decode
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd4;

  localparam logic [ALU_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_W-1:0] ALU_AND  = 2'b10;
  localparam logic [ALU_W-1:0] ALU_XOR  = 2'b11;

  // All controller strobes for one cycle
  typedef struct packed {
    logic              ir_load;
    logic              pc_inc;
    logic              mem_read;
    logic              mem_write;
    logic              jump;
    logic              skip;
    logic              acc_write;
    logic              alu_to_acc;
    logic [ALU_W-1:0]  alu_op;
    logic              reg_write;
    logic              halted;
  } ctrl_word_t;

  // Opcodes whose EXEC phase waits on the memory handshake
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
           (op == OP_LDA) || (op == OP_STO);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: (state, latched opcode, latched acc_zero) -> strobes.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    op_q,
  input  logic               skz_q,
  output ctrl_word_t         cw_c
);

  logic [ALU_W-1:0] alu_sel_c;
  logic             alu_src_c;

  // ALU op / ACC source for the latched opcode, shared by EXEC and WB
  always_comb begin
    alu_sel_c = ALU_PASS;
    alu_src_c = 1'b0;
    unique case (op_q)
      OP_ADD: begin alu_sel_c = ALU_ADD; alu_src_c = 1'b1; end
      OP_AND: begin alu_sel_c = ALU_AND; alu_src_c = 1'b1; end
      OP_XOR: begin alu_sel_c = ALU_XOR; alu_src_c = 1'b1; end
      default: begin alu_sel_c = ALU_PASS; alu_src_c = 1'b0; end
    endcase
  end

  // Per-state strobe decode; anything not driven stays 0
  always_comb begin
    cw_c = '0;
    unique case (state)
      ST_FETCH: begin
        cw_c.mem_read = 1'b1;
        cw_c.ir_load  = 1'b1;
      end
      ST_DECODE: begin
        cw_c.pc_inc = 1'b1;
      end
      ST_EXEC: begin
        unique case (op_q)
          OP_JMP: cw_c.jump = 1'b1;
          OP_SKZ: cw_c.skip = skz_q;
          OP_STO: cw_c.mem_write = 1'b1;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            cw_c.mem_read   = 1'b1;
            cw_c.alu_to_acc = alu_src_c;
            cw_c.alu_op     = alu_sel_c;
          end
          default: cw_c = '0;
        endcase
      end
      ST_WB: begin
        cw_c.acc_write  = 1'b1;
        cw_c.reg_write  = 1'b1;
        cw_c.alu_to_acc = alu_src_c;
        cw_c.alu_op     = alu_sel_c;
      end
      ST_HALT: begin
        cw_c.halted = 1'b1;
      end
      default: cw_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM control unit for the 8-bit accumulator CPU.
// Optional feature macro: CTRL_TIMEOUT_EN (bounded mem_ready wait, bus_error pulse).
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                mem_read,
  output logic                mem_write,
  output logic                jump,
  output logic                skip,
  output logic                acc_write,
  output logic                alu_to_acc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [2:0]          state
);

  // Reject configurations the decode cannot represent
  if (OPCODE_W < 3 || ALU_OP_W < 2 || TIMEOUT == 0) begin : g_param_check
    $error("multicycle_controller: bad OPCODE_W/ALU_OP_W/TIMEOUT");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               skz_q, skz_d;
  logic               illegal_q, illegal_d;
  logic               illegal_c;
  logic               expire_c;
  ctrl_word_t         cw_c;

  // Codes 8 and above exist only when the opcode field is wider than 3 bits
  assign illegal_c = (32'(opcode) >= 32'd8);

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;

  if (TIMEOUT > 255) begin : g_tmo_check
    $error("multicycle_controller: TIMEOUT exceeds 8-bit counter");
  end

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
  logic             waiting_c;

  // A wait cycle is FETCH or a memory EXEC with the handshake still low
  assign waiting_c = !mem_ready &&
                     ((state_q == ST_FETCH) || ((state_q == ST_EXEC) && is_mem_op(op_q)));
  assign expire_c  = waiting_c && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Timeout counter: clears on expiry or any state change, else counts wait cycles
  always_comb begin
    tmo_d     = tmo_q;
    bus_err_d = 1'b0;
    if (expire_c) begin
      tmo_d     = '0;
      bus_err_d = 1'b1;
    end else if (state_d != state_q) begin
      tmo_d = '0;
    end else if (waiting_c) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Timeout counter and bus_error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_error = bus_err_q;
`else
  assign expire_c  = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Next-state, opcode latch and illegal-op pulse logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    skz_d     = skz_q;
    illegal_d = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d  = opcode[2:0];
        skz_d = acc_zero;
        if (illegal_c) begin
          state_d   = ST_FETCH;
          illegal_d = 1'b1;
        end else if (opcode[2:0] == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (op_q)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: if (mem_ready) state_d = ST_WB;
          OP_STO:                         if (mem_ready) state_d = ST_FETCH;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: if (resume) state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
    if (expire_c) state_d = ST_FETCH;
  end

  // State register, latched opcode/acc_zero and illegal_op pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      skz_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      skz_q     <= skz_d;
      illegal_q <= illegal_d;
    end
  end

  ctrl_decode u_decode (
    .state (state_q),
    .op_q  (op_q),
    .skz_q (skz_q),
    .cw_c  (cw_c)
  );

  assign ir_load    = cw_c.ir_load;
  assign pc_inc     = cw_c.pc_inc;
  assign mem_read   = cw_c.mem_read;
  assign mem_write  = cw_c.mem_write;
  assign jump       = cw_c.jump;
  assign skip       = cw_c.skip;
  assign acc_write  = cw_c.acc_write;
  assign alu_to_acc = cw_c.alu_to_acc;
  assign alu_op     = ALU_OP_W'(cw_c.alu_op);
  assign reg_write  = cw_c.reg_write;
  assign halted     = cw_c.halted;
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule
